// File: rtl/io_btn_debounce.sv
// Multi-channel push-button debouncer: synchroniser, per-channel stability FSM,
// edge pulses and sticky press events with write-one-to-clear.
//
// state     | meaning
// IDLE_LOW  | debounced level released, synchronised input agrees
// CHK_HIGH  | input pressed, counting consecutive pressed cycles
// IDLE_HIGH | debounced level pressed, synchronised input agrees
// CHK_LOW   | input released, counting consecutive released cycles
module io_btn_debounce #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_CH-1:0] i_btn,
    input  logic [CNT_W-1:0]  i_stable_cnt,
    input  logic [NUM_CH-1:0] i_clr,
    output logic [NUM_CH-1:0] o_btn_level,
    output logic [NUM_CH-1:0] o_btn_rise,
    output logic [NUM_CH-1:0] o_btn_fall,
    output logic [NUM_CH-1:0] o_evt_sticky,
    output logic              o_evt_any
);

    typedef enum logic [1:0] {IDLE_LOW, CHK_HIGH, IDLE_HIGH, CHK_LOW} state_t;

    logic [NUM_CH-1:0] btn_pressed;
    logic [CNT_W-1:0]  thresh;

    assign btn_pressed = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;
    assign thresh      = (i_stable_cnt == '0) ? CNT_W'(1) : i_stable_cnt;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync;
        state_t                 state;
        logic [CNT_W-1:0]       cnt;
        logic [CNT_W:0]         cnt_inc;
        logic [CNT_W-1:0]       cnt_nxt;
        logic                   s;
        logic                   hit;
        logic                   level_q;
        logic                   rise_q;
        logic                   fall_q;
        logic                   sticky_q;

        assign s       = sync[SYNC_STAGES-1];
        assign cnt_inc = {1'b0, cnt} + (CNT_W+1)'(1);
        assign cnt_nxt = (cnt == '1) ? cnt : cnt_inc[CNT_W-1:0];
        // Compared against the live threshold so lowering it mid-check takes effect next edge.
        assign hit     = cnt_inc >= {1'b0, thresh};

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                sync     <= '0;
                state    <= IDLE_LOW;
                cnt      <= '0;
                level_q  <= 1'b0;
                rise_q   <= 1'b0;
                fall_q   <= 1'b0;
                sticky_q <= 1'b0;
            end else begin
                sync   <= {sync[SYNC_STAGES-2:0], btn_pressed[g]};
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                // A press in the same cycle overrides this clear further down.
                if (i_clr[g]) sticky_q <= 1'b0;
                case (state)
                    IDLE_LOW: begin
                        if (s) begin
                            if (thresh == CNT_W'(1)) begin
                                level_q  <= 1'b1;
                                rise_q   <= 1'b1;
                                sticky_q <= 1'b1;
                                state    <= IDLE_HIGH;
                            end else begin
                                state <= CHK_HIGH;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    CHK_HIGH: begin
                        if (!s) begin
                            state <= IDLE_LOW;
                            cnt   <= '0;
                        end else if (hit) begin
                            level_q  <= 1'b1;
                            rise_q   <= 1'b1;
                            sticky_q <= 1'b1;
                            state    <= IDLE_HIGH;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                    IDLE_HIGH: begin
                        if (!s) begin
                            if (thresh == CNT_W'(1)) begin
                                level_q <= 1'b0;
                                fall_q  <= 1'b1;
                                state   <= IDLE_LOW;
                            end else begin
                                state <= CHK_LOW;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    CHK_LOW: begin
                        if (s) begin
                            state <= IDLE_HIGH;
                            cnt   <= '0;
                        end else if (hit) begin
                            level_q <= 1'b0;
                            fall_q  <= 1'b1;
                            state   <= IDLE_LOW;
                            cnt     <= '0;
                        end else begin
                            cnt <= cnt_nxt;
                        end
                    end
                    default: begin
                        state <= IDLE_LOW;
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign o_btn_level[g]  = level_q;
        assign o_btn_rise[g]   = rise_q;
        assign o_btn_fall[g]   = fall_q;
        assign o_evt_sticky[g] = sticky_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) o_evt_any <= 1'b0;
        else       o_evt_any <= |o_evt_sticky;
    end

endmodule

// File: tb/tb_io_btn_debounce.sv
// Bench for io_btn_debounce: directed scenarios plus random traffic, all checked
// against a run-length reference model of the debounce rules.
module tb_io_btn_debounce;
    localparam int NUM_CH = 4;
    localparam int CNT_W  = 16;
    localparam int SYNC   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] btn;
    logic [CNT_W-1:0]  tcnt;
    logic [NUM_CH-1:0] clr;
    logic [NUM_CH-1:0] o_btn_level, o_btn_rise, o_btn_fall, o_evt_sticky;
    logic              o_evt_any;

    always #5 clk = ~clk;

    io_btn_debounce #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .SYNC_STAGES(SYNC), .ACTIVE_LOW(1)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_btn(btn), .i_stable_cnt(tcnt), .i_clr(clr),
        .o_btn_level(o_btn_level), .o_btn_rise(o_btn_rise), .o_btn_fall(o_btn_fall),
        .o_evt_sticky(o_evt_sticky), .o_evt_any(o_evt_any)
    );

    wire [4*NUM_CH:0] dut_vec = {o_btn_level, o_btn_rise, o_btn_fall, o_evt_sticky, o_evt_any};

    int checks = 0;
    int errors = 0;

    // Reference model: pressed samples become visible SYNC edges later; a level
    // flips once the visible value has differed from it for T consecutive edges.
    logic [NUM_CH-1:0] m_hist[$];
    logic [NUM_CH-1:0] m_level = '0, m_rise = '0, m_fall = '0, m_sticky = '0;
    logic              m_any = 1'b0;
    int                m_run[NUM_CH];

    function automatic logic [4*NUM_CH:0] exp_vec();
        return {m_level, m_rise, m_fall, m_sticky, m_any};
    endfunction

    task automatic tick();
        int t;
        logic [NUM_CH-1:0] s;
        logic any_next;
        @(posedge clk);
        if (rst) begin
            m_hist.delete();
            m_level = '0; m_rise = '0; m_fall = '0; m_sticky = '0; m_any = 1'b0;
            for (int c = 0; c < NUM_CH; c++) m_run[c] = 0;
        end else begin
            t = (tcnt == '0) ? 1 : int'(tcnt);
            s = (m_hist.size() >= SYNC) ? m_hist[m_hist.size() - SYNC] : '0;
            m_hist.push_back(~btn);
            if (m_hist.size() > SYNC) void'(m_hist.pop_front());
            any_next = |m_sticky;
            m_rise = '0;
            m_fall = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                if (s[c] != m_level[c]) begin
                    m_run[c]++;
                    if (m_run[c] >= t) begin
                        m_level[c] = s[c];
                        m_run[c]   = 0;
                        m_rise[c]  = s[c];
                        m_fall[c]  = ~s[c];
                    end
                end else begin
                    m_run[c] = 0;
                end
                if (m_rise[c])   m_sticky[c] = 1'b1;
                else if (clr[c]) m_sticky[c] = 1'b0;
            end
            m_any = any_next;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; btn = '1; clr = '0; tcnt = CNT_W'(4);
        repeat (3) tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL reset_outputs got=%h exp=0", dut_vec);
        end
        rst = 1'b0;
        repeat (3) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL reset_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_clean_press();
        tcnt = CNT_W'(4);
        btn[0] = 1'b0;
        for (int d = 0; d <= 6; d++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL press_model d=%0d got=%h exp=%h", d, dut_vec, exp_vec());
            end
            if (d == 4) begin
                checks++;
                if (o_btn_level[0] !== 1'b0) begin
                    errors++; $display("FAIL press_early d=4 level=%b exp=0", o_btn_level[0]);
                end
            end
            if (d == 5) begin
                checks++;
                if ({o_btn_level[0], o_btn_rise[0], o_evt_sticky[0], o_evt_any} !== 4'b1110) begin
                    errors++;
                    $display("FAIL press_edge lvl/rise/sticky/any=%b%b%b%b exp=1110",
                             o_btn_level[0], o_btn_rise[0], o_evt_sticky[0], o_evt_any);
                end
            end
            if (d == 6) begin
                checks++;
                if ({o_btn_rise[0], o_evt_any} !== 2'b01) begin
                    errors++; $display("FAIL press_after rise/any=%b%b exp=01", o_btn_rise[0], o_evt_any);
                end
            end
        end
    endtask

    task automatic test_release_clear();
        clr[0] = 1'b1;
        tick();
        clr[0] = 1'b0;
        checks++;
        if (o_evt_sticky[0] !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL clear_sticky sticky=%b got=%h exp=%h", o_evt_sticky[0], dut_vec, exp_vec());
        end
        btn[0] = 1'b1;
        for (int d = 0; d <= 6; d++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL release_model d=%0d got=%h exp=%h", d, dut_vec, exp_vec());
            end
            if (d == 4) begin
                checks++;
                if (o_btn_level[0] !== 1'b1) begin
                    errors++; $display("FAIL release_early level=%b exp=1", o_btn_level[0]);
                end
            end
            if (d == 5) begin
                checks++;
                if ({o_btn_level[0], o_btn_fall[0]} !== 2'b01) begin
                    errors++; $display("FAIL release_edge lvl/fall=%b%b exp=01", o_btn_level[0], o_btn_fall[0]);
                end
            end
            if (d == 6) begin
                checks++;
                if ({o_btn_fall[0], o_evt_sticky[0]} !== 2'b00) begin
                    errors++; $display("FAIL release_after fall/sticky=%b%b exp=00", o_btn_fall[0], o_evt_sticky[0]);
                end
            end
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        logic lvl_seen = 1'b0;
        tcnt = CNT_W'(4);
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 4; k++) begin
                btn[0] = (k == 3);
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL bounce_model r=%0d got=%h exp=%h", r, dut_vec, exp_vec());
                end
                rises    += int'(o_btn_rise[0]);
                lvl_seen |= o_btn_level[0];
            end
        end
        checks++;
        if (rises != 0 || lvl_seen !== 1'b0) begin
            errors++; $display("FAIL bounce_quiet rises=%0d level_seen=%b exp 0/0", rises, lvl_seen);
        end
        btn[0] = 1'b0;
        repeat (12) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL steady_model t=%0t got=%h exp=%h", $time, dut_vec, exp_vec());
            end
            rises += int'(o_btn_rise[0]);
        end
        checks++;
        if (rises != 1 || o_btn_level[0] !== 1'b1) begin
            errors++; $display("FAIL steady_press rises=%0d level=%b exp 1/1", rises, o_btn_level[0]);
        end
    endtask

    task automatic test_collision();
        tcnt = CNT_W'(4);
        btn[1] = 1'b0;
        for (int d = 0; d <= 5; d++) begin
            clr[1] = (d == 5);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL collide_model d=%0d got=%h exp=%h", d, dut_vec, exp_vec());
            end
        end
        clr[1] = 1'b0;
        checks++;
        if ({o_btn_rise[1], o_evt_sticky[1]} !== 2'b11) begin
            errors++; $display("FAIL collide_set rise/sticky=%b%b exp=11", o_btn_rise[1], o_evt_sticky[1]);
        end
        tick();
        checks++;
        if (o_evt_sticky[1] !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL collide_hold sticky=%b got=%h exp=%h", o_evt_sticky[1], dut_vec, exp_vec());
        end
    endtask

    task automatic test_threshold();
        tcnt = '0;
        btn[2] = 1'b0;
        for (int d = 0; d <= 2; d++) begin
            tick();
            if (d >= 1) begin
                checks++;
                if ({o_btn_level[2], o_btn_rise[2]} !== ((d == 2) ? 2'b11 : 2'b00)) begin
                    errors++; $display("FAIL t0_latency d=%0d lvl/rise=%b%b", d, o_btn_level[2], o_btn_rise[2]);
                end
            end
        end
        tcnt = CNT_W'(100);
        btn[2] = 1'b1;
        for (int d = 0; d <= 51; d++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL t100_model d=%0d got=%h exp=%h", d, dut_vec, exp_vec());
            end
        end
        checks++;
        if (o_btn_level[2] !== 1'b1) begin
            errors++; $display("FAIL t100_hold level=%b exp=1", o_btn_level[2]);
        end
        tcnt = CNT_W'(2);
        tick();
        checks++;
        if ({o_btn_level[2], o_btn_fall[2]} !== 2'b01) begin
            errors++; $display("FAIL t_lowered lvl/fall=%b%b exp=01", o_btn_level[2], o_btn_fall[2]);
        end
    endtask

    task automatic test_reset_mid_check();
        tcnt = CNT_W'(4);
        btn[3] = 1'b0;
        for (int d = 0; d <= 3; d++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (dut_vec !== '0) begin
            errors++; $display("FAIL midrst_outputs got=%h exp=0", dut_vec);
        end
        rst = 1'b0;
        for (int d = 0; d <= 5; d++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL midrst_model d=%0d got=%h exp=%h", d, dut_vec, exp_vec());
            end
            if (d == 4 || d == 5) begin
                checks++;
                if ({o_btn_level[3], o_btn_rise[3]} !== ((d == 5) ? 2'b11 : 2'b00)) begin
                    errors++; $display("FAIL midrst_rise d=%0d lvl/rise=%b%b", d, o_btn_level[3], o_btn_rise[3]);
                end
            end
        end
    endtask

    task automatic test_random();
        int idx;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, NUM_CH - 1);
                btn[idx] = ~btn[idx];
            end
            if ($urandom_range(0, 19) == 0) tcnt = CNT_W'($urandom_range(0, 6));
            clr = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '0;
            rst = ($urandom_range(0, 199) == 0);
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random_model i=%0d got=%h exp=%h", i, dut_vec, exp_vec());
            end
        end
        rst = 1'b0;
        clr = '0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release_clear();
        test_bounce();
        test_collision();
        test_threshold();
        test_reset_mid_check();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
